// File: rtl/multicycle_controller.sv
// Sequencing FSM and decoder for the multicycle RV32I-subset core.
// Drives every datapath select/strobe, one instruction phase per state; stalls on MemReady.
module multicycle_controller #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state, next_state;
  logic   mem_ready;
  logic   pc_write, mem_write, ir_write, reg_write, illegal_op;

  assign mem_ready = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  // Only R-type subtraction uses funct7b5; unsupported funct3 falls back to add.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_r, input logic f7);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  ctl = 3'b101;
      3'b110:  ctl = 3'b011;
      3'b111:  ctl = 3'b010;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        next_state = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, 1'b1, funct7b5);
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, 1'b0, funct7b5);
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write   = Zero;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // reset is active-low: strobes are suppressed while it is asserted so an aborted access never writes.
  assign PCWrite  = reset & pc_write;
  assign MemWrite = reset & mem_write;
  assign IRWrite  = reset & ir_write;
  assign RegWrite = reset & reg_write;
  assign Illegal  = reset & illegal_op;
  assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle comparison against an instruction-level
// phase model, plus hand-computed literal expectations for cycle counts and strobe totals.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State)
  );

  // X in an expected field means the datapath does not use that select in this phase.
  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int checks = 0, errors = 0;
  int rwSeen = 0, mwSeen = 0, pcwSeen = 0, illSeen = 0, adrMwSeen = 0;
  logic [2:0] lastExecAlu = 3'b111;
  logic [1:0] lastJalImm = 2'b00;

  logic [6:0] curOp = 7'd0;
  logic [2:0] curF3 = 3'd0;
  logic       curF7 = 1'b0, curZero = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    if ($isunknown(exp)) return;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] immFor(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic intent of the instruction: sub only for R-type funct3=000 with bit 30 set.
  function automatic logic [2:0] aluFor(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && o == OP_R && f7) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic isLegal(input logic [6:0] o);
    return (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL);
  endfunction

  function automatic exp_t modelCycle(input int ph, input logic rstLow, input logic mr);
    exp_t m;
    m     = 'x;
    m.st  = ph[3:0];
    m.pcw = 1'b0; m.mw = 1'b0; m.irw = 1'b0; m.rw = 1'b0; m.ill = 1'b0;
    m.imm = immFor(curOp);
    if (rstLow) begin
      m.st = 4'd0; m.adr = 1'b0; m.sa = 2'b00; m.sb = 2'b10; m.rs = 2'b10; m.alu = 3'b000;
      return m;
    end
    case (ph)
      0:  begin m.adr = 1'b0; m.sa = 2'b00; m.sb = 2'b10; m.alu = 3'b000; m.rs = 2'b10;
                m.irw = mr; m.pcw = mr; end
      1:  begin m.sa = 2'b01; m.sb = 2'b01; m.alu = 3'b000; m.ill = !isLegal(curOp); end
      2:  begin m.sa = 2'b10; m.sb = 2'b01; m.alu = 3'b000; end
      3:  m.adr = 1'b1;
      4:  begin m.rs = 2'b01; m.rw = 1'b1; end
      5:  begin m.adr = 1'b1; m.mw = 1'b1; end
      6:  begin m.sa = 2'b10; m.sb = 2'b00; m.alu = aluFor(curOp, curF3, curF7); end
      7:  begin m.sa = 2'b10; m.sb = 2'b01; m.alu = aluFor(curOp, curF3, curF7); end
      8:  begin m.rs = 2'b00; m.rw = 1'b1; end
      9:  begin m.sa = 2'b10; m.sb = 2'b00; m.alu = 3'b001; m.rs = 2'b00; m.pcw = curZero; end
      10: begin m.sa = 2'b01; m.sb = 2'b10; m.alu = 3'b000; m.rs = 2'b00; m.pcw = 1'b1; m.rw = 1'b1; end
      default: ;
    endcase
    return m;
  endfunction

  // One clock of stimulus: drive after the edge, queue what the outputs must be this cycle.
  task automatic step(input int ph, input logic mr, input logic rstLow);
    @(posedge clk);
    #1;
    reset    = ~rstLow;
    MemReady = mr;
    op       = curOp;
    funct3   = curF3;
    funct7b5 = curF7;
    Zero     = curZero;
    expQ.push_back(modelCycle(ph, rstLow, mr));
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                               input int fetchWaits, input int memWaits, output int cycles);
    curOp = o; curF3 = f3; curF7 = f7; curZero = z;
    cycles = 0;
    for (int i = 0; i < fetchWaits; i++) begin step(0, 1'b0, 1'b0); cycles++; end
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    cycles += 2;
    case (o)
      OP_LW: begin
        step(2, 1'b1, 1'b0);
        for (int i = 0; i < memWaits; i++) step(3, 1'b0, 1'b0);
        step(3, 1'b1, 1'b0);
        step(4, 1'b1, 1'b0);
        cycles += 3 + memWaits;
      end
      OP_SW: begin
        step(2, 1'b1, 1'b0);
        for (int i = 0; i < memWaits; i++) step(5, 1'b0, 1'b0);
        step(5, 1'b1, 1'b0);
        cycles += 2 + memWaits;
      end
      OP_R:   begin step(6, 1'b1, 1'b0); step(8, 1'b1, 1'b0); cycles += 2; end
      OP_I:   begin step(7, 1'b1, 1'b0); step(8, 1'b1, 1'b0); cycles += 2; end
      OP_BEQ: begin step(9, 1'b1, 1'b0); cycles += 1; end
      OP_JAL: begin step(10, 1'b1, 1'b0); cycles += 1; end
      default: ;
    endcase
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t x);
    chk("State", State, x.st);
    chk("PCWrite", {3'b0, PCWrite}, {3'b0, x.pcw});
    chk("AdrSrc", {3'b0, AdrSrc}, {3'b0, x.adr});
    chk("MemWrite", {3'b0, MemWrite}, {3'b0, x.mw});
    chk("IRWrite", {3'b0, IRWrite}, {3'b0, x.irw});
    chk("RegWrite", {3'b0, RegWrite}, {3'b0, x.rw});
    chk("ResultSrc", {2'b0, ResultSrc}, {2'b0, x.rs});
    chk("ALUSrcA", {2'b0, ALUSrcA}, {2'b0, x.sa});
    chk("ALUSrcB", {2'b0, ALUSrcB}, {2'b0, x.sb});
    chk("ALUControl", {1'b0, ALUControl}, {1'b0, x.alu});
    chk("ImmSrc", {2'b0, ImmSrc}, {2'b0, x.imm});
    chk("Illegal", {3'b0, Illegal}, {3'b0, x.ill});
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
    if (RegWrite === 1'b1) rwSeen++;
    if (MemWrite === 1'b1) mwSeen++;
    if (PCWrite === 1'b1) pcwSeen++;
    if (Illegal === 1'b1) illSeen++;
    if (MemWrite === 1'b1 && AdrSrc === 1'b1) adrMwSeen++;
    if (State === 4'd6 || State === 4'd7) lastExecAlu = ALUControl;
    if (State === 4'd10) lastJalImm = ImmSrc;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cyc, rw0, mw0, pcw0, ill0, am0;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1);

    rw0 = rwSeen;
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, cyc);
    chk("addAlu", {1'b0, lastExecAlu}, 4'b0000);
    chk("addCycles", cyc[3:0], 4'd4);
    chk("addRegWrites", 4'(rwSeen - rw0), 4'd1);
    applyStimulus(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, cyc);
    chk("subAlu", {1'b0, lastExecAlu}, 4'b0001);
    applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 1, 0, cyc);
    chk("addiAlu", {1'b0, lastExecAlu}, 4'b0000);
    chk("addiStallCycles", cyc[3:0], 4'd5);
    applyStimulus(OP_R, 3'b010, 1'b0, 1'b0, 0, 0, cyc);
    chk("sltAlu", {1'b0, lastExecAlu}, 4'b0101);
    applyStimulus(OP_I, 3'b110, 1'b1, 1'b0, 0, 0, cyc);
    applyStimulus(OP_R, 3'b111, 1'b0, 1'b0, 0, 0, cyc);
    applyStimulus(OP_I, 3'b001, 1'b0, 1'b0, 0, 0, cyc);

    rw0 = rwSeen;
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 0, 2, cyc);
    chk("lwCycles", cyc[3:0], 4'd7);
    chk("lwRegWrites", 4'(rwSeen - rw0), 4'd1);

    rw0 = rwSeen; mw0 = mwSeen; am0 = adrMwSeen;
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 0, 1, cyc);
    chk("swMemWrites", 4'(mwSeen - mw0), 4'd2);
    chk("swAdrDuringWrite", 4'(adrMwSeen - am0), 4'd2);
    chk("swRegWrites", 4'(rwSeen - rw0), 4'd0);

    pcw0 = pcwSeen;
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, cyc);
    chk("beqTakenPcWrites", 4'(pcwSeen - pcw0), 4'd2);
    pcw0 = pcwSeen;
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, cyc);
    chk("beqNotTakenPcWrites", 4'(pcwSeen - pcw0), 4'd1);

    rw0 = rwSeen;
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, cyc);
    chk("jalCycles", cyc[3:0], 4'd3);
    chk("jalImm", {2'b0, lastJalImm}, 4'b0011);
    chk("jalRegWrites", 4'(rwSeen - rw0), 4'd1);

    ill0 = illSeen;
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, cyc);
    chk("illegalPulses", 4'(illSeen - ill0), 4'd1);
    chk("illegalCycles", cyc[3:0], 4'd2);

    // Abort a stalled store by pulling reset low while MEMWRITE holds MemWrite high.
    curOp = OP_SW; curF3 = 3'b010; curF7 = 1'b0; curZero = 1'b0;
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    step(5, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("rstMidMemWrite", {3'b0, MemWrite}, 4'd0);
    chk("rstMidState", State, 4'd0);
    step(0, 1'b1, 1'b1);

    rw0 = rwSeen;
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, cyc);
    chk("postResetAdd", 4'(rwSeen - rw0), 4'd1);
    step(0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
